conc_stim_player: RTL
=====================

# conc_stim_player

Synthesizable stimulus player sitting directly upstream of the b14 core: it replays a preloaded program of 32-bit stimulus words, one per clock, driving b14's `datai[30:0]` from bits 30:0 and its `__obs` input from bit 31. It replaces the behavioural program-counter/ROM logic of the simulation harness, so the same stimulus image can run on FPGA or in gate-level sim. It is loaded through a simple write port, started and stopped by a controller, and reports progress for logging.

## Interface
- `DEPTH`, 21, number of stimulus words in the program store.
- `AW`, $clog2(DEPTH), program address width.
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset); deassertion is synchronous to `clock` at the source.
- `load_en`  in  1  write strobe for program store.
- `load_addr`  in  AW  write address; `load_addr >= DEPTH` ignored.
- `load_data`  in  32  word to store; bit 31 = obs, bits 30:0 = datai.
- `length`  in  AW+1  words to play, sampled on accepted `start`; range 0..DEPTH, larger values clamp to DEPTH.
- `start`  in  1  begin playback from word 0 (accepted only in IDLE or DONE).
- `stop`  in  1  abort playback.
- `loop_en`  in  1  wrap to word 0 after last word instead of finishing; sampled each cycle.
- `datai`  out  31  to b14 `datai`; registered.
- `obs`  out  1  to b14 `__obs`; registered.
- `out_valid`  out  1  high in each cycle a new word is presented.
- `pc`  out  32  count of words emitted since start (log counter, wraps at 2^32).
- `busy`  out  1  state == PLAY.
- `done`  out  1  state == DONE.
- `load_err`  out  1  one-cycle pulse when a load is attempted during PLAY (write dropped).

## Operation
- States: IDLE, PLAY, DONE. Reset -> IDLE.
- IDLE/DONE + `start`: latch clamped `length` into `len_q`, `rd_ptr`=0, `pc`=0, `done`=0; if `len_q`==0 go DONE, else PLAY.
- PLAY each cycle: `datai`<=mem[rd_ptr][30:0], `obs`<=mem[rd_ptr][31], `out_valid`<=1, `pc`<=pc+1. If `rd_ptr`==len_q-1: `loop_en` -> `rd_ptr`=0, stay PLAY; else -> DONE. Otherwise `rd_ptr`+1.
- PLAY + `stop`: -> IDLE, no word emitted that cycle, `datai`/`obs` hold. `stop` beats `start`; `stop` outside PLAY: no effect.
- DONE/IDLE: `datai`, `obs` hold last emitted value; `out_valid`=0.
- Loads: write on the edge `load_en` is high, allowed in IDLE/DONE. In PLAY the write is dropped and `load_err` pulses next cycle.
- `load_en`+`start` same cycle in IDLE: write commits on that edge; first word read one cycle later sees new data.
- Program store is not reset; contents survive `reset`.

## Timing
- Reset values: `datai`=0, `obs`=0, `out_valid`=0, `pc`=0, `busy`=0, `done`=0, `load_err`=0.
- `start` sampled at edge k -> PLAY after k; word n appears after edge k+1+n with `out_valid`=1, `pc`=n+1.
- Non-looping length L: last word after edge k+L, `done`=1 from same edge, `out_valid`=0 after edge k+L+1.
- Zero-bubble wrap when looping: word L-1 then word 0 on consecutive cycles.
- `reset` asserted mid-playback: all outputs to reset values immediately (async), state IDLE.

## Structure
- Package `conc_stim_pkg`: state enum, `WORD_W`=32, `OBS_BIT`=31, `DATAI_W`=31.
- One sub-module `conc_stim_ram`: DEPTH×32 store, one synchronous write port, one asynchronous read port; no reset.
- Top holds FSM, pointers, output registers.

## Test plan
- Load words 0..4 = {32'h8000_0001, 32'h0000_0002, 32'h8000_0003, 32'h0000_0004, 32'h7FFF_FFFF}, length 5, start -> five consecutive `out_valid` cycles with obs 1,0,1,0,0 and datai 1,2,3,4,31'h7FFF_FFFF; `done`=1 after fifth word, outputs hold 31'h7FFF_FFFF.
- Same program, length 3, `loop_en`=1 for 10 cycles -> datai 1,2,3,1,2,3,1,2,3,1, `pc`=10, `busy` held 1.
- `stop` at third PLAY cycle -> IDLE, datai holds 2, `out_valid`=0; following `start` replays from word 0.
- `length`=0 start -> DONE next edge, no `out_valid`; `length`=31 with DEPTH 21 -> exactly 21 words.
- `load_en` during PLAY -> `load_err` one-cycle pulse, stored word unchanged on replay; `load_en`+`start` in IDLE to address 0 -> first emitted word is the new data.
- Assert `reset` mid-playback -> all outputs 0 asynchronously; after release, `start` replays preserved program contents.

Source files
------------

// File: rtl/conc_stim_pkg.sv
// Shared types and widths for the stimulus player that feeds the b14 core.
package conc_stim_pkg;

   localparam int unsigned WORD_W  = 32;
   localparam int unsigned OBS_BIT = 31;
   localparam int unsigned DATAI_W = 31;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/conc_stim_ram.sv
// Program store: one synchronous write port, one asynchronous read port, no reset.
module conc_stim_ram
   import conc_stim_pkg::*;
#(
   parameter int unsigned DEPTH = 21,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [WORD_W-1:0] wr_data,
   input  logic [AW-1:0]     rd_addr,
   output logic [WORD_W-1:0] rd_data
);

   logic [WORD_W-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/conc_stim_player.sv
// Replays a preloaded program of 32-bit stimulus words into b14, one word per clock.
module conc_stim_player
   import conc_stim_pkg::*;
#(
   parameter int unsigned DEPTH = 21,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               load_en,
   input  logic [AW-1:0]      load_addr,
   input  logic [WORD_W-1:0]  load_data,
   input  logic [AW:0]        length,
   input  logic               start,
   input  logic               stop,
   input  logic               loop_en,
   output logic [DATAI_W-1:0] datai,
   output logic               obs,
   output logic               out_valid,
   output logic [31:0]        pc,
   output logic               busy,
   output logic               done,
   output logic               load_err
);

   localparam int unsigned LW = AW + 1;
   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

   state_e            state;
   logic [AW-1:0]     rd_ptr;
   logic [LW-1:0]     len_q;
   logic [WORD_W-1:0] rd_word;
   logic [LW-1:0]     len_clamped_c;
   logic              last_c;
   logic              wr_en_c;

   assign len_clamped_c = (length > DEPTH_L) ? DEPTH_L : length;
   assign last_c        = ({1'b0, rd_ptr} == (len_q - LW'(1)));
   // Writes are only legal while the store is not being read out.
   assign wr_en_c       = load_en && (state != ST_PLAY) && ({1'b0, load_addr} < DEPTH_L);

   conc_stim_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clock   (clock),
      .wr_en   (wr_en_c),
      .wr_addr (load_addr),
      .wr_data (load_data),
      .rd_addr (rd_ptr),
      .rd_data (rd_word)
   );

   // Playback FSM, pointers and registered outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         rd_ptr    <= '0;
         len_q     <= '0;
         datai     <= '0;
         obs       <= 1'b0;
         out_valid <= 1'b0;
         pc        <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         load_err  <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         load_err  <= load_en && (state == ST_PLAY);
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  len_q  <= len_clamped_c;
                  rd_ptr <= '0;
                  pc     <= '0;
                  if (len_clamped_c == '0) begin
                     state <= ST_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state <= ST_PLAY;
                     busy  <= 1'b1;
                     done  <= 1'b0;
                  end
               end
            end
            ST_PLAY: begin
               if (stop) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b0;
               end else begin
                  datai     <= rd_word[DATAI_W-1:0];
                  obs       <= rd_word[OBS_BIT];
                  out_valid <= 1'b1;
                  pc        <= pc + 32'd1;
                  if (last_c) begin
                     if (loop_en) begin
                        rd_ptr <= '0;
                     end else begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end
                  end else begin
                     rd_ptr <= rd_ptr + AW'(1);
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule
